// File: rtl/console_pkg.sv
// Shared constants and state type for the 50x30 text console writer.
package console_pkg;

  localparam int COLS = 50;
  localparam int ROWS = 30;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_ROW} console_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream to video-memory writer: cursor tracking, control codes and
// blanking of the screen / next row, with a registered single-cycle write port.
module text_console_writer
  import console_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              CLK_CPU,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              video_write_enable,
  output logic [7:0]        video_write_data,
  output logic [ADDR_W-1:0] video_write_addr,
  output logic [4:0]        cursor_row,
  output logic [5:0]        cursor_col,
  output logic              busy
);

  // state      | meaning
  // IDLE       | accepting bytes
  // CLR_SCREEN | blanking every cell, clr_ptr = cell address
  // CLR_ROW    | blanking the cursor row, clr_ptr = column
  if (COLS * ROWS > 2 ** ADDR_W) begin : g_size_check
    $error("COLS*ROWS does not fit the video-memory address width");
  end

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_END   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(COLS);
  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

  console_state_t    state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  logic [ADDR_W-1:0] row_base, row_base_nx;
  logic [4:0]        row_nx;
  logic [5:0]        col_nx;
  logic              we_nx;
  logic [7:0]        wdata_nx;
  logic [ADDR_W-1:0] waddr_nx;
  logic              take;
  logic              advance;

  assign char_ready = (state == IDLE);
  // busy is held low while reset is asserted so every output reads 0 then
  assign busy       = reset && (state != IDLE);
  assign take       = char_valid && char_ready;

  always_comb begin
    state_nx    = state;
    clr_ptr_nx  = clr_ptr;
    row_base_nx = row_base;
    row_nx      = cursor_row;
    col_nx      = cursor_col;
    we_nx       = 1'b0;
    wdata_nx    = BLANK;
    waddr_nx    = '0;
    advance     = 1'b0;
    case (state)
      CLR_SCREEN: begin
        we_nx    = 1'b1;
        waddr_nx = clr_ptr;
        if (clr_ptr == LAST_CELL) begin
          state_nx    = IDLE;
          clr_ptr_nx  = '0;
          row_base_nx = '0;
          row_nx      = '0;
          col_nx      = '0;
        end else begin
          clr_ptr_nx = clr_ptr + 1'b1;
        end
      end
      CLR_ROW: begin
        we_nx    = 1'b1;
        waddr_nx = row_base + clr_ptr;
        if (clr_ptr == ROW_END) begin
          state_nx   = IDLE;
          clr_ptr_nx = '0;
          col_nx     = '0;
        end else begin
          clr_ptr_nx = clr_ptr + 1'b1;
        end
      end
      default: begin
        if (take) begin
          if (is_printable(char_data)) begin
            we_nx    = 1'b1;
            wdata_nx = char_data;
            waddr_nx = row_base + ADDR_W'(cursor_col);
            if (cursor_col == LAST_COL) advance = 1'b1;
            else                        col_nx  = cursor_col + 6'd1;
          end else begin
            case (char_data)
              CH_LF: advance = 1'b1;
              CH_CR: col_nx  = '0;
              CH_BS: begin
                if (cursor_col != 6'd0) begin
                  col_nx   = cursor_col - 6'd1;
                  we_nx    = 1'b1;
                  waddr_nx = row_base + ADDR_W'(cursor_col - 6'd1);
                end
              end
              CH_FF: begin
                state_nx   = CLR_SCREEN;
                clr_ptr_nx = '0;
              end
              default: ;
            endcase
          end
          // the printable write above still uses the old row_base
          if (advance) begin
            state_nx   = CLR_ROW;
            clr_ptr_nx = '0;
            col_nx     = '0;
            if (cursor_row == LAST_ROW) begin
              row_nx      = '0;
              row_base_nx = '0;
            end else begin
              row_nx      = cursor_row + 5'd1;
              row_base_nx = row_base + STRIDE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK_CPU or negedge reset) begin
    if (!reset) begin
      state              <= CLR_SCREEN;
      clr_ptr            <= '0;
      row_base           <= '0;
      cursor_row         <= '0;
      cursor_col         <= '0;
      video_write_enable <= 1'b0;
      video_write_data   <= '0;
      video_write_addr   <= '0;
    end else begin
      state              <= state_nx;
      clr_ptr            <= clr_ptr_nx;
      row_base           <= row_base_nx;
      cursor_row         <= row_nx;
      cursor_col         <= col_nx;
      video_write_enable <= we_nx;
      video_write_data   <= wdata_nx;
      video_write_addr   <= waddr_nx;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized bench for text_console_writer: a queue-based model of pending
// writes and cursor position checked against the DUT on every cycle.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        video_write_enable;
  logic [7:0]  video_write_data;
  logic [10:0] video_write_addr;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;

  text_console_writer dut (
    .CLK_CPU(clk),
    .reset(rst_n),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .video_write_enable(video_write_enable),
    .video_write_data(video_write_data),
    .video_write_addr(video_write_addr),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // model: writes still owed by a clear, and the cursor as row/col numbers
  int   clrq[$];
  bit   ff_pending;
  int   m_row, m_col;
  bit   exp_we;
  int   exp_addr, exp_data;
  logic [18:0] wlog[$];

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    clrq.delete();
    for (int i = 0; i < 1500; i++) clrq.push_back(i);
    ff_pending = 1'b1;
    m_row = 0;
    m_col = 0;
    exp_we = 1'b0;
  endtask

  task automatic line_adv();
    m_row = (m_row + 1) % 30;
    m_col = 0;
    for (int i = 0; i < 50; i++) clrq.push_back(m_row * 50 + i);
  endtask

  task automatic model_step();
    exp_we = 1'b0;
    if (clrq.size() > 0) begin
      exp_we   = 1'b1;
      exp_data = 32;
      exp_addr = clrq.pop_front();
      if (clrq.size() == 0 && ff_pending) begin
        ff_pending = 1'b0;
        m_row = 0;
        m_col = 0;
      end
    end else if (char_valid) begin
      int b;
      b = int'(char_data);
      if (b >= 32 && b <= 126) begin
        exp_we   = 1'b1;
        exp_data = b;
        exp_addr = m_row * 50 + m_col;
        m_col++;
        if (m_col == 50) line_adv();
      end else if (b == 10) begin
        line_adv();
      end else if (b == 13) begin
        m_col = 0;
      end else if (b == 8) begin
        if (m_col > 0) begin
          m_col--;
          exp_we   = 1'b1;
          exp_data = 32;
          exp_addr = m_row * 50 + m_col;
        end
      end else if (b == 12) begin
        for (int i = 0; i < 1500; i++) clrq.push_back(i);
        ff_pending = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_we", int'(video_write_enable), 0);
        chk("rst_data", int'(video_write_data), 0);
        chk("rst_addr", int'(video_write_addr), 0);
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_col", int'(cursor_col), 0);
      end else begin
        chk("we", int'(video_write_enable), int'(exp_we));
        if (exp_we) begin
          chk("wdata", int'(video_write_data), exp_data);
          chk("waddr", int'(video_write_addr), exp_addr);
        end
        chk("ready", int'(char_ready), int'(clrq.size() == 0));
        chk("busy", int'(busy), int'(clrq.size() != 0));
        chk("row", int'(cursor_row), m_row);
        chk("col", int'(cursor_col), m_col);
        if (video_write_enable) wlog.push_back({video_write_addr, video_write_data});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 199);
    if (r < 150)      return 8'($urandom_range(32, 126));
    else if (r < 165) return 8'h0A;
    else if (r < 175) return 8'h0D;
    else if (r < 188) return 8'h08;
    else if (r < 189) return 8'h0C;
    else if (r < 194) return 8'h07;
    else              return 8'($urandom_range(127, 255));
  endfunction

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // power-up clear
    wait_idle();
    chk("boot_writes", wlog.size(), 1500);
    chk("boot_first", int'(wlog[0]), 32);
    chk("boot_last", int'(wlog[1499]), (1499 << 8) | 32);
    chk("boot_row", int'(cursor_row), 0);
    chk("boot_col", int'(cursor_col), 0);

    // "AB"
    wlog.delete();
    send(8'h41);
    send(8'h42);
    settle();
    chk("ab_writes", wlog.size(), 2);
    chk("ab_first", int'(wlog[0]), 8'h41);
    chk("ab_second", int'(wlog[1]), (1 << 8) | 8'h42);
    chk("ab_col", int'(cursor_col), 2);
    chk("ab_model_col", m_col, 2);

    // printable at the last column of row 2
    send(8'h0D);
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 49; i++) send(8'($urandom_range(33, 126)));
    settle();
    chk("prex_row", int'(cursor_row), 2);
    chk("prex_col", int'(cursor_col), 49);
    wlog.delete();
    send(8'h58);
    wait_idle();
    chk("x_writes", wlog.size(), 51);
    chk("x_char", int'(wlog[0]), (149 << 8) | 8'h58);
    chk("x_clr_first", int'(wlog[1]), (150 << 8) | 32);
    chk("x_clr_last", int'(wlog[50]), (199 << 8) | 32);
    chk("x_row", int'(cursor_row), 3);
    chk("x_col", int'(cursor_col), 0);

    // LF on the last row wraps and clears row 0
    for (int i = 0; i < 26; i++) send(8'h0A);
    wait_idle();
    chk("r29_row", int'(cursor_row), 29);
    wlog.delete();
    send(8'h0A);
    wait_idle();
    chk("wrap_writes", wlog.size(), 50);
    chk("wrap_first", int'(wlog[0]), 32);
    chk("wrap_last", int'(wlog[49]), (49 << 8) | 32);
    chk("wrap_row", int'(cursor_row), 0);
    chk("wrap_model_row", m_row, 0);
    wlog.delete();
    send(8'h0D);
    send(8'h08);
    settle();
    chk("crbs_writes", wlog.size(), 0);
    chk("crbs_col", int'(cursor_col), 0);

    // BS from column 5, then an ignored control byte
    for (int i = 0; i < 5; i++) send(8'h71);
    settle();
    chk("bs_pre_col", int'(cursor_col), 5);
    wlog.delete();
    send(8'h08);
    settle();
    chk("bs_write", int'(wlog[0]), (4 << 8) | 32);
    chk("bs_col", int'(cursor_col), 4);
    wlog.delete();
    send(8'h07);
    settle();
    chk("bel_writes", wlog.size(), 0);
    chk("bel_col", int'(cursor_col), 4);

    // reset in the middle of a form-feed clear
    wlog.delete();
    send(8'h0C);
    n = 0;
    @(negedge clk);
    while (!(video_write_enable && video_write_addr == 11'd700) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ff_reached_700", int'(video_write_addr), 700);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_we", int'(video_write_enable), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wlog.delete();
    wait_idle();
    chk("rerun_writes", wlog.size(), 1500);
    chk("rerun_first", int'(wlog[0]), 32);
    chk("rerun_last", int'(wlog[1499]), (1499 << 8) | 32);

    // random traffic
    for (int k = 0; k < 700; k++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
